// File: rtl/shift_seq.sv
// shift_seq: valid/ready sequencer that drives an external shift_reg through one parallel load and N shifts.
// A shadow copy of the register is reloaded whenever the block is not shifting, because shift_reg has no enable.
module shift_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic [CNT_W-1:0] in_count,
   input  logic             in_fill,
   output logic             sr_S,
   output logic [WIDTH-1:0] sr_A,
   output logic             sr_psload,
   output logic             sr_lrshift,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] shift_cnt
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] shadow;
   logic dir, fill, accept;
   assign accept = in_valid && in_ready;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         shadow    <= '0;
         shift_cnt <= '0;
         dir       <= 1'b0;
         fill      <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            shadow    <= in_data;
            dir       <= in_dir;
            fill      <= in_fill;
            shift_cnt <= in_count > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : in_count;
         end else if (state == SHIFT) begin
            shadow    <= dir ? {fill, shadow[WIDTH-1:1]} : {shadow[WIDTH-2:0], fill};
            shift_cnt <= shift_cnt - CNT_W'(1);
         end
      end
   end
   always_comb begin
      state_nx   = state == IDLE  ? (accept ? LOAD : IDLE) :
                   state == LOAD  ? (shift_cnt == '0 ? DONE : SHIFT) :
                   state == SHIFT ? (shift_cnt == CNT_W'(1) ? DONE : SHIFT) : IDLE;
      in_ready   = state == IDLE;
      busy       = state != IDLE;
      done       = state == DONE;
      // every non-SHIFT cycle reloads the shadow so shift_reg holds its value
      sr_psload  = state != SHIFT;
      sr_A       = shadow;
      sr_S       = fill;
      sr_lrshift = dir;
      result     = shadow;
   end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: random and directed commands against an arithmetic model of the load-then-shift sequence,
// with a behavioural shift_reg attached to the sequencer outputs.
module tb_shift_seq;
   logic clk = 0, reset = 0, in_valid = 0, in_dir = 0, in_fill = 0;
   logic [7:0] in_data = '0;
   logic [3:0] in_count = '0;
   logic in_ready, sr_S, sr_psload, sr_lrshift, busy, done;
   logic [7:0] sr_A, result, y = '0;
   logic [3:0] shift_cnt;
   int checks = 0, errors = 0;

   shift_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_dir(in_dir), .in_count(in_count), .in_fill(in_fill), .sr_S(sr_S), .sr_A(sr_A),
      .sr_psload(sr_psload), .sr_lrshift(sr_lrshift), .busy(busy), .done(done),
      .result(result), .shift_cnt(shift_cnt)
   );

   always #5 clk = ~clk;

   // external shift_reg: no reset, no enable
   always @(posedge clk) y <= sr_psload ? sr_A : (sr_lrshift ? {sr_S, y[7:1]} : {y[6:0], sr_S});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // word after n fill bits have been pushed in from the given side
   function automatic logic [7:0] model(input logic [7:0] d, input logic dr, input logic fl, input int n);
      logic [7:0] ones = 8'hFF;
      if (n == 0) return d;
      if (!dr) return (d << n) | (fl ? ~(ones << n) : 8'h00);
      return (d >> n) | (fl ? ~(ones >> n) : 8'h00);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_psload"}, sr_psload, 1);
      chk({tag, "_A"}, sr_A, 0);
      chk({tag, "_S"}, sr_S, 0);
      chk({tag, "_lr"}, sr_lrshift, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_cnt"}, shift_cnt, 0);
   endtask

   // cycle m counts edges since in_valid was driven: LOAD at 1, SHIFT at 2..n+1, DONE at n+2, IDLE at n+3
   task automatic run(input logic [7:0] d, input logic dr, input logic fl, input logic [3:0] c, input bit hold);
      int n;
      logic [7:0] e;
      n = c > 8 ? 8 : int'(c);
      in_valid = 1; in_data = d; in_dir = dr; in_fill = fl; in_count = c;
      for (int m = 1; m <= n + 3; m++) begin
         step;
         if (m == 1) begin
            if (hold) in_data = 8'h55;
            else in_valid = 0;
         end
         e = m == 1 ? d : model(d, dr, fl, (m - 2) > n ? n : m - 2);
         chk("busy", busy, m <= n + 2);
         chk("ready", in_ready, m == n + 3);
         chk("done", done, m == n + 2);
         chk("psload", sr_psload, !(m >= 2 && m <= n + 1));
         chk("result", result, e);
         chk("sr_A", sr_A, e);
         if (m == 1) chk("cnt_load", shift_cnt, n);
         if (m >= 2 && m <= n + 1) begin
            chk("lrshift", sr_lrshift, dr);
            chk("S", sr_S, fl);
            chk("cnt", shift_cnt, n - (m - 2));
         end
         if (m >= 2) chk("shift_reg_y", y, e);
      end
   endtask

   initial begin
      step; step;
      chk_idle_reset("reset");
      reset = 1;
      step;
      run(8'b1011_0001, 0, 1, 4'd3, 0);
      chk("left_final", result, 8'b1000_1111);
      reset = 0;
      step; step;
      chk_idle_reset("reset_idle");
      reset = 1;
      step;
      run(8'hA5, 1, 0, 4'd8, 0);
      run(8'h3C, 0, 0, 4'd0, 0);
      run(8'h00, 0, 1, 4'd12, 1);
      chk("clamp_final", result, 8'hFF);
      run(8'h55, 0, 1, 4'd12, 0);
      in_valid = 1; in_data = 8'hC3; in_dir = 0; in_fill = 1; in_count = 4'd5;
      step;
      in_valid = 0;
      step; step;
      reset = 0;
      step;
      chk_idle_reset("abort");
      reset = 1;
      for (int i = 0; i < 8; i++) begin
         step;
         chk("abort_no_done", done, 0);
         chk("abort_idle", in_ready, 1);
      end
      run(8'h96, 1, 1, 4'd5, 0);
      for (int i = 0; i < 25; i++) begin
         run(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
         repeat ($urandom_range(0, 2)) step;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Upstream sequencer for the 8-bit `shift_reg` block.
- Accepts a word plus a shift command over a valid/ready handshake.
- Drives `shift_reg`'s serial-in, parallel-in, `psload` and `lrshift` inputs to perform one parallel load followed by N single-bit shifts.
- Keeps a shadow copy of the register contents. Whenever it is not shifting, it reloads that copy so `shift_reg` holds its value, because `shift_reg` has no enable.
- Pulses `done` and presents the final word on `result`.

Parameters:
WIDTH, 8, data width; matches `shift_reg`.
CNT_W, 4, width of the shift-count field; must hold values 0..WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  command valid.
in_ready  output  1  block can accept a command.
in_data  input  WIDTH  word to load.
in_dir  input  1  shift direction: 0 = left, 1 = right.
in_count  input  CNT_W  number of shifts; values above WIDTH are clamped to WIDTH.
in_fill  input  1  serial bit shifted in on every shift.
sr_S  output  1  to `shift_reg` S.
sr_A  output  WIDTH  to `shift_reg` A.
sr_psload  output  1  to `shift_reg` psload: 1 = parallel load, 0 = shift.
sr_lrshift  output  1  to `shift_reg` lrshift: 0 = left (S enters the LSB), 1 = right (S enters the MSB).
busy  output  1  high in LOAD, SHIFT and DONE.
done  output  1  one-cycle pulse when the sequence completes.
result  output  WIDTH  shadow word; equals `shift_reg` contents one edge after each update.
shift_cnt  output  CNT_W  shifts remaining.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Outputs are Moore-decoded from state and registers.
- Reset: on a rising clk edge with reset==0, the following registers clear:
  - state = IDLE, shadow = 0, shift_cnt = 0;
  - captured dir/fill = 0.
  - Resulting outputs: in_ready=1, busy=0, done=0, sr_psload=1, sr_A=0, sr_S=0, sr_lrshift=0, result=0.
- Reset mid-operation: aborts immediately; no done pulse is generated.
- IDLE:
  - in_ready=1, sr_psload=1, sr_A=shadow, so `shift_reg` holds.
  - On in_valid & in_ready at an edge: shadow<=in_data; dir, fill captured; shift_cnt<=min(in_count, WIDTH); go to LOAD.
- LOAD (1 cycle):
  - sr_psload=1, sr_A=shadow (the new word).
  - Next state is DONE if shift_cnt==0, otherwise SHIFT.
- SHIFT:
  - sr_psload=0, sr_lrshift=dir, sr_S=fill.
  - Each edge: left gives shadow<={shadow[WIDTH-2:0], fill}; right gives shadow<={fill, shadow[WIDTH-1:1]}.
  - Each edge: shift_cnt<=shift_cnt-1.
  - When shift_cnt==1, the next state is DONE.
- DONE (1 cycle):
  - done=1, sr_psload=1, sr_A=shadow (the hold value); result holds the final word.
  - Next state is IDLE.
- Latency: for a command accepted at edge k with N shifts:
  - LOAD is the cycle after edge k;
  - SHIFT spans the cycles after edges k+2 .. k+N+1;
  - done is high in the cycle after edge k+N+2.
  - busy is high for N+2 cycles. in_ready returns high in the cycle after DONE.
- in_valid while in_ready==0 is ignored; commands are not queued.
- sr_S and sr_lrshift are don't-care outside SHIFT but must be driven to captured fill/dir (never X).
- Invariant: outside reset, `shift_reg` Y equals result one edge after every state change.

Test Plan:
1. Reset: hold reset=0 for 2 edges mid-idle -> in_ready=1, busy=0, done=0, sr_psload=1, sr_A=8'h00, result=8'h00.
2. Left shift: in_data=8'b1011_0001, in_dir=0, in_count=3, in_fill=1, accepted at edge k -> sr_A after each shift edge = 8'b0110_0011, 8'b1100_0111, 8'b1000_1111; done high only after edge k+5; result=8'b1000_1111; `shift_reg` Y matches.
3. Right full shift: in_data=8'hA5, in_dir=1, in_count=8, in_fill=0 -> busy high 10 cycles; result=8'h00; sr_lrshift=1 during all 8 SHIFT cycles.
4. Zero count: in_data=8'h3C, in_count=0 -> LOAD then DONE; done high after edge k+2; result=8'h3C; sr_psload never 0.
5. Clamp/ignore: in_count=12, in_fill=1, in_dir=0, in_data=8'h00 -> exactly 8 shifts, result=8'hFF. A second in_valid (data 8'h55) held during busy is not accepted; it is accepted only after done.
6. Mid-operation reset: reset=0 at the second SHIFT cycle of a 5-shift command -> next cycle IDLE, result=8'h00, no done pulse; a fresh command afterwards completes normally.
